// File: rtl/grant_locking_arbiter_pkg.sv
// Shared types and constants for the two-requester grant arbiter.
// Field widths, grant payload struct and the lock FSM state enum.
package grant_locking_arbiter_pkg;

   localparam int unsigned BEAT_W  = 3;
   localparam int unsigned CXID_W  = 1;
   localparam int unsigned MXID_W  = 2;
   localparam int unsigned GTYPE_W = 4;
   localparam int unsigned DATA_W  = 64;
   localparam int unsigned CID_W   = 1;
   localparam int unsigned STAT_W  = 16;

   localparam logic [GTYPE_W-1:0] G_TYPE_DATA_BLOCK = 4'h5;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   typedef struct packed {
      logic [BEAT_W-1:0]  addr_beat;
      logic [CXID_W-1:0]  client_xact_id;
      logic [MXID_W-1:0]  manager_xact_id;
      logic               is_builtin_type;
      logic [GTYPE_W-1:0] g_type;
      logic [DATA_W-1:0]  data;
      logic [CID_W-1:0]   client_id;
   } grant_t;

   // Non-builtin grants and builtin data-block grants carry a full block.
   function automatic logic is_multibeat(input grant_t g);
      return !g.is_builtin_type || (g.g_type == G_TYPE_DATA_BLOCK);
   endfunction

endpackage

// File: rtl/grant_locking_arbiter_if.sv
// Grant handshake bundle: two requester ports, one arbitrated output port.
// The arbiter connects through the slave modport, the requester/sink side through master.
interface grant_locking_arbiter_if;
   import grant_locking_arbiter_pkg::*;

   logic   io_in_0_valid;
   logic   io_in_0_ready;
   grant_t io_in_0_bits;
   logic   io_in_1_valid;
   logic   io_in_1_ready;
   grant_t io_in_1_bits;
   logic   io_out_ready;
   logic   io_out_valid;
   grant_t io_out_bits;
   logic   io_chosen;

   modport slave (
      input  io_in_0_valid, io_in_0_bits, io_in_1_valid, io_in_1_bits, io_out_ready,
      output io_in_0_ready, io_in_1_ready, io_out_valid, io_out_bits, io_chosen
   );

   modport master (
      output io_in_0_valid, io_in_0_bits, io_in_1_valid, io_in_1_bits, io_out_ready,
      input  io_in_0_ready, io_in_1_ready, io_out_valid, io_out_bits, io_chosen
   );

endinterface

// File: rtl/grant_locking_arbiter_rr_pick2.sv
// Two-way round-robin pick: the requester that did not win last goes first.
// With neither valid the previous winner stays selected.
module rr_pick2 (
   input  logic [1:0] valid,
   input  logic       last,
   output logic       winner
);

   always_comb begin
      winner = last;
      if (valid[~last]) winner = ~last;
   end

endmodule

// File: rtl/grant_locking_arbiter.sv
// Two-requester grant arbiter that locks onto one requester for a multi-beat block.
// Optional per-requester fired-beat counters are built when GRANT_ARB_STATS_EN is defined.
module grant_locking_arbiter
   import grant_locking_arbiter_pkg::*;
#(
   parameter int unsigned N_BEATS = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   grant_locking_arbiter_if.slave io
`ifdef GRANT_ARB_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_beats_0,
   output logic [STAT_W-1:0]     stat_beats_1
`endif
);

   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

   state_e state_q, state_d;
   logic   lock_owner_q, lock_owner_d;
   logic   last_winner_q, last_winner_d;
   logic   hold_q, hold_d;
   logic   hold_idx_q, hold_idx_d;

   logic   rr_winner;
   logic   chosen;
   logic   sel_valid;
   grant_t sel_bits;
   logic   fire;

   rr_pick2 u_rr_pick2 (
      .valid  ({io.io_in_1_valid, io.io_in_0_valid}),
      .last   (last_winner_q),
      .winner (rr_winner)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         lock_owner_q  <= 1'b0;
         last_winner_q <= 1'b1;
         hold_q        <= 1'b0;
         hold_idx_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         lock_owner_q  <= lock_owner_d;
         last_winner_q <= last_winner_d;
         hold_q        <= hold_d;
         hold_idx_q    <= hold_idx_d;
      end
   end

   // A stalled winner (valid && !ready) is remembered so a late request cannot steal the port.
   always_comb begin
      state_d       = state_q;
      lock_owner_d  = lock_owner_q;
      last_winner_d = last_winner_q;
      chosen        = rr_winner;

      if (state_q == LOCKED)  chosen = lock_owner_q;
      else if (hold_q)        chosen = hold_idx_q;

      sel_valid  = chosen ? io.io_in_1_valid : io.io_in_0_valid;
      sel_bits   = chosen ? io.io_in_1_bits  : io.io_in_0_bits;
      fire       = sel_valid && io.io_out_ready;
      hold_d     = sel_valid && !io.io_out_ready;
      hold_idx_d = chosen;

      case (state_q)
         IDLE: begin
            if (fire) begin
               last_winner_d = chosen;
               if (is_multibeat(sel_bits) && (sel_bits.addr_beat != LAST_BEAT)) begin
                  state_d      = LOCKED;
                  lock_owner_d = chosen;
               end
            end
         end
         LOCKED: begin
            if (fire && (sel_bits.addr_beat == LAST_BEAT)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign io.io_out_valid  = sel_valid;
   assign io.io_out_bits   = sel_bits;
   assign io.io_chosen     = chosen;
   assign io.io_in_0_ready = io.io_out_ready && !chosen;
   assign io.io_in_1_ready = io.io_out_ready &&  chosen;

`ifdef GRANT_ARB_STATS_EN
   logic [STAT_W-1:0] stat_0_q, stat_1_q;

   // Fired-beat counters wrap naturally at the top of their range.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_0_q <= '0;
         stat_1_q <= '0;
      end else if (fire) begin
         if (chosen) stat_1_q <= stat_1_q + STAT_W'(1);
         else        stat_0_q <= stat_0_q + STAT_W'(1);
      end
   end

   assign stat_beats_0 = stat_0_q;
   assign stat_beats_1 = stat_1_q;
`endif

endmodule

// File: tb/tb_grant_locking_arbiter.sv
// Scoreboard bench for grant_locking_arbiter: expected fires are queued with the stimulus
// and popped when the output handshake completes; directed per-cycle checks cover locking.
module tb_grant_locking_arbiter;
   import grant_locking_arbiter_pkg::*;

   typedef struct {
      logic   idx;
      grant_t bits;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   grant_locking_arbiter_if bus ();

`ifdef GRANT_ARB_STATS_EN
   logic [15:0] stat0, stat1;
`endif

   grant_locking_arbiter #(.N_BEATS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (bus)
`ifdef GRANT_ARB_STATS_EN
      ,
      .stat_beats_0 (stat0),
      .stat_beats_1 (stat1)
`endif
   );

   exp_t   exp_q[$];
   grant_t src0[$];
   grant_t src1[$];
   logic   en0 = 1'b1;
   logic   en1 = 1'b1;
   logic   f0, f1;
   int     n_cmp = 0;
   int     n_err = 0;

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic grant_t mk(input logic [2:0] beat, input logic builtin,
                                 input logic [3:0] gt, input logic [63:0] d, input logic cid);
      grant_t g;
      g                 = '0;
      g.addr_beat       = beat;
      g.client_xact_id  = d[0];
      g.manager_xact_id = d[2:1];
      g.is_builtin_type = builtin;
      g.g_type          = gt;
      g.data            = d;
      g.client_id       = cid;
      return g;
   endfunction

   task automatic expect_fire(input logic idx, input grant_t g);
      exp_t e;
      e.idx  = idx;
      e.bits = g;
      exp_q.push_back(e);
   endtask

   task automatic drive();
      bus.io_in_0_valid = en0 && (src0.size() > 0);
      bus.io_in_0_bits  = (src0.size() > 0) ? src0[0] : grant_t'('0);
      bus.io_in_1_valid = en1 && (src1.size() > 0);
      bus.io_in_1_bits  = (src1.size() > 0) ? src1[0] : grant_t'('0);
   endtask

   // Sample on the falling edge and retire any completed transfer against the scoreboard.
   task automatic settle();
      exp_t e;
      @(negedge clk);
      f0 = bus.io_in_0_valid && bus.io_in_0_ready;
      f1 = bus.io_in_1_valid && bus.io_in_1_ready;
      if (!reset && bus.io_out_valid && bus.io_out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_fire", 80'(bus.io_chosen), 80'(2));
         end else begin
            e = exp_q.pop_front();
            check("sb_chosen", 80'(bus.io_chosen), 80'(e.idx));
            check("sb_bits", 80'(bus.io_out_bits), 80'(e.bits));
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (!reset && f0) void'(src0.pop_front());
      if (!reset && f1) void'(src1.pop_front());
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         drive();
         settle();
         advance();
      end
   endtask

   grant_t g, d0, d1;

   initial begin
      reset = 1'b1;
      bus.io_out_ready = 1'b1;
      en0 = 1'b0;
      en1 = 1'b0;
      drive();
      @(negedge clk);
      check("rst_out_valid", 80'(bus.io_out_valid), 80'(0));
      check("rst_chosen_idle", 80'(bus.io_chosen), 80'(1));
      en1 = 1'b1;
      src1.push_back(mk(3'd0, 1'b1, 4'h3, 64'hAAAA, 1'b1));
      drive();
      #1;
      check("rst_valid_follows_in", 80'(bus.io_out_valid), 80'(1));
      check("rst_in1_ready", 80'(bus.io_in_1_ready), 80'(1));
      src1.delete();
      en0 = 1'b1;
      drive();
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Alternating single-beat putAcks from both requesters.
      for (int i = 0; i < 4; i++) begin
         d0 = mk(3'd0, 1'b1, 4'h3, 64'h1000 + 64'(i), 1'b0);
         d1 = mk(3'd0, 1'b1, 4'h3, 64'h2000 + 64'(i), 1'b1);
         src0.push_back(d0);
         src1.push_back(d1);
         expect_fire(1'b0, d0);
         expect_fire(1'b1, d1);
      end
      step(8);

      // Requester 0 block while requester 1 stays valid and blocked.
      for (int b = 0; b < 8; b++) begin
         g = mk(3'(b), 1'b1, 4'h5, 64'h3000 + 64'(b), 1'b0);
         src0.push_back(g);
         expect_fire(1'b0, g);
      end
      d1 = mk(3'd0, 1'b1, 4'h3, 64'h3100, 1'b1);
      src1.push_back(d1);
      expect_fire(1'b1, d1);
      g = mk(3'd0, 1'b1, 4'h1, 64'h3101, 1'b1);
      src1.push_back(g);
      expect_fire(1'b1, g);
      for (int b = 0; b < 8; b++) begin
         drive();
         settle();
         check("blk_in1_ready", 80'(bus.io_in_1_ready), 80'(0));
         advance();
      end
      drive();
      settle();
      check("blk_in1_after", 80'(bus.io_in_1_ready), 80'(1));
      advance();
      step(1);

      // Lock owner goes quiet mid-block; nothing may interleave.
      for (int b = 0; b < 8; b++) begin
         g = mk(3'(b), 1'b0, 4'h0, 64'h4000 + 64'(b), 1'b0);
         src0.push_back(g);
         expect_fire(1'b0, g);
      end
      d1 = mk(3'd0, 1'b1, 4'h3, 64'h4100, 1'b1);
      src1.push_back(d1);
      expect_fire(1'b1, d1);
      step(4);
      en0 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         drive();
         settle();
         check("gap_out_valid", 80'(bus.io_out_valid), 80'(0));
         check("gap_chosen", 80'(bus.io_chosen), 80'(0));
         check("gap_in1_ready", 80'(bus.io_in_1_ready), 80'(0));
         advance();
      end
      en0 = 1'b1;
      step(5);

      // Backpressure: choice and payload must hold until ready returns.
      d0 = mk(3'd0, 1'b1, 4'h3, 64'h5000, 1'b0);
      d1 = mk(3'd0, 1'b1, 4'h3, 64'h5100, 1'b1);
      src0.push_back(d0);
      src1.push_back(d1);
      expect_fire(1'b0, d0);
      expect_fire(1'b1, d1);
      bus.io_out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive();
         settle();
         check("stall_chosen", 80'(bus.io_chosen), 80'(0));
         check("stall_bits", 80'(bus.io_out_bits), 80'(d0));
         advance();
      end
      bus.io_out_ready = 1'b1;
      step(2);

      // Reset in the middle of a requester 1 block.
      for (int b = 0; b < 8; b++) begin
         g = mk(3'(b), 1'b1, 4'h5, 64'h6000 + 64'(b), 1'b1);
         src1.push_back(g);
         if (b < 4) expect_fire(1'b1, g);
      end
      step(4);
      bus.io_out_ready = 1'b0;
      reset = 1'b1;
      src1.delete();
      d0 = mk(3'd0, 1'b1, 4'h3, 64'h7000, 1'b0);
      d1 = mk(3'd0, 1'b1, 4'h3, 64'h7100, 1'b1);
      src0.push_back(d0);
      src1.push_back(d1);
      drive();
      @(negedge clk);
      check("midrst_chosen", 80'(bus.io_chosen), 80'(0));
      check("midrst_out_valid", 80'(bus.io_out_valid), 80'(1));
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.io_out_ready = 1'b1;
      expect_fire(1'b0, d0);
      expect_fire(1'b1, d1);
      step(2);

      check("sb_drain", 80'(exp_q.size()), 80'(0));

`ifdef GRANT_ARB_STATS_EN
      reset = 1'b1;
      @(negedge clk);
      check("stat0_reset", 80'(stat0), 80'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.io_in_1_valid = 1'b0;
      bus.io_in_0_valid = 1'b1;
      bus.io_in_0_bits  = mk(3'd0, 1'b1, 4'h3, 64'h8000, 1'b0);
      repeat (65538) @(posedge clk);
      #1;
      bus.io_in_0_valid = 1'b0;
      @(negedge clk);
      check("stat0_wrap", 80'(stat0), 80'(2));
      check("stat1_zero", 80'(stat1), 80'(0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
